alu4_req_scheduler: RTL and testbench
=====================================

Name: alu4_req_scheduler

Overview:
Shares one WIDTH-bit logic/arithmetic unit (NOT/AND/OR/ADD, with zero and carry flags) between two requesters. Requests are arbitrated round-robin, and operands are latched and executed in a registered stage. The result, Z, CF and requester ID are presented on a valid/ready output port. The block sits between the control sequencers and the shared flag-producing ALU datapath.

Parameters:
WIDTH, 4, operand/result width in bits
OPW, 2, opcode width (fixed encoding, see Behaviour)

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  reset, asynchronous, active-low
REQ0_VALID  input  1  requester 0 has an operation
REQ0_READY  output  1  requester 0 accepted this cycle
REQ0_OP  input  OPW  requester 0 opcode
REQ0_A  input  WIDTH  requester 0 operand A
REQ0_B  input  WIDTH  requester 0 operand B
REQ1_VALID / REQ1_READY / REQ1_OP / REQ1_A / REQ1_B  same as requester 0, for requester 1
RES_VALID  output  1  result available
RES_READY  input  1  consumer takes result
RES_OUT  output  WIDTH  result value
RES_Z  output  1  zero flag, RES_OUT == 0
RES_CF  output  1  carry-out, ADD only
RES_ID  output  1  requester that issued the result
CLR_STICKY  input  1  clear sticky flags (optional feature)
STICKY_Z  output  1  accumulated zero flag (optional feature)
STICKY_CF  output  1  accumulated carry flag (optional feature)

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous and active-low.
- Reset values: state IDLE; all outputs 0, including READYs, RES_*, STICKY_*; round-robin pointer LAST=1, so requester 0 wins first.
- Opcodes:
  - 00: NOT A. B is ignored.
  - 01: A AND B.
  - 10: A OR B.
  - 11: A + B, computed at WIDTH+1 bits. RES_OUT is the low WIDTH bits; CF is bit WIDTH.
  - CF = 0 for every opcode except ADD.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - REQn_READY is combinational: REQn_READY = REQn_VALID and granted(n).
  - Grant rule with one request valid: that request is granted.
  - Grant rule with both valid: the requester != LAST is granted.
  - On grant: latch OP, A, B and the ID; set LAST = ID; go to EXEC.
  - With no request valid, stay in IDLE.
  - At most one READY is high per cycle.
- EXEC: ALU computes from the latched operands. Register RES_OUT, RES_Z, RES_CF and RES_ID; go to RESP.
- RESP:
  - RES_VALID = 1. RES_* stay stable until RES_VALID && RES_READY; on that handshake go to IDLE.
  - Both READYs are 0 in EXEC and RESP.
- Latency: handshake in cycle N -> RES_VALID high in cycle N+2. Back-to-back throughput is one op per 3 cycles when RES_READY is held high.
- Backpressure: RESP holds indefinitely while RES_READY = 0. Requesters see READY = 0 throughout.
- Simultaneous events:
  - A request arriving during EXEC/RESP waits.
  - RES handshake and a new request in the same cycle: the request is accepted in the next cycle, from IDLE.
- VALID drop: a requester that drops VALID before being granted simply loses its slot; no state is kept.
- Reset mid-operation: an in-flight op is discarded; RES_VALID falls immediately (asynchronous); LAST returns to 1.

Optional Feature:
Macro ALU4_STICKY_FLAGS_EN.
- Defined:
  - On each RES handshake, STICKY_Z |= RES_Z and STICKY_CF |= RES_CF.
  - CLR_STICKY = 1 clears both on the next edge.
  - Clear and set in the same cycle: set wins, i.e. the new flag value is stored.
- Undefined: STICKY_Z and STICKY_CF are tied to 0, CLR_STICKY is ignored, and no registers are inferred.

Decomposition:
- Package alu4_pkg:
  - opcode localparams OP_NOT=2'b00, OP_AND=2'b01, OP_OR=2'b10, OP_ADD=2'b11;
  - FSM state encoding S_IDLE, S_EXEC, S_RESP;
  - default WIDTH.
- One combinational sub-module, alu4_core (op, a, b -> out, z, cf), instantiated once in EXEC.
- The round-robin grant is inline.

Test Plan:
1. Reset, then REQ0 op=00 A=4'b0000 -> REQ0_READY in cycle 0; two cycles later RES_OUT=4'b1111, Z=0, CF=0, ID=0.
2. REQ1 op=11 A=4'b1001 B=4'b0111 -> RES_OUT=4'b0000, Z=1, CF=1, ID=1.
3. Both VALID continuously, RES_READY=1 -> grants alternate 0,1,0,1, each 3 cycles apart; never two READYs together.
4. RES_READY=0 for 5 cycles in RESP -> RES_* stable, READYs 0; RES_READY=1 -> IDLE next cycle, pending request granted.
5. RST_N pulsed low during EXEC -> RES_VALID=0; the next grant goes to REQ0 even if REQ1 was last.
6. With ALU4_STICKY_FLAGS_EN: an ADD 4'b1111+4'b0001 result, then an AND 4'b0011&4'b1100 result -> STICKY_Z=1, STICKY_CF=1. CLR_STICKY coinciding with a Z=1 result -> STICKY_Z stays 1.

Source files
------------

// File: rtl/alu4_pkg.sv
// Shared definitions for the alu4 request scheduler: default widths, opcode encoding, FSM states.
package alu4_pkg;

    localparam int unsigned ALU4_WIDTH = 4;
    localparam int unsigned ALU4_OPW   = 2;

    localparam logic [ALU4_OPW-1:0] OP_NOT = 2'b00;
    localparam logic [ALU4_OPW-1:0] OP_AND = 2'b01;
    localparam logic [ALU4_OPW-1:0] OP_OR  = 2'b10;
    localparam logic [ALU4_OPW-1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu4_core.sv
// Combinational NOT/AND/OR/ADD unit producing result, zero flag and carry-out.
module alu4_core
    import alu4_pkg::*;
#(
    parameter int unsigned WIDTH = ALU4_WIDTH,
    parameter int unsigned OPW   = ALU4_OPW
) (
    input  logic [OPW-1:0]   i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_out_c,
    output logic             o_z_c,
    output logic             o_cf_c
);

    logic [WIDTH:0] w_sum;

    assign w_sum = (WIDTH+1)'(i_a) + (WIDTH+1)'(i_b);

    // Carry is only meaningful for ADD; every logic op reports CF = 0.
    always_comb begin
        o_out_c = '0;
        o_cf_c  = 1'b0;
        case (i_op)
            OP_NOT:  o_out_c = ~i_a;
            OP_AND:  o_out_c = i_a & i_b;
            OP_OR:   o_out_c = i_a | i_b;
            default: begin
                o_out_c = w_sum[WIDTH-1:0];
                o_cf_c  = w_sum[WIDTH];
            end
        endcase
    end

    assign o_z_c = (o_out_c == '0);

endmodule

// File: rtl/alu4_req_scheduler.sv
// Round-robin sharing of one alu4_core between two requesters, result on a valid/ready port.
// Optional sticky Z/CF accumulation is built only when ALU4_STICKY_FLAGS_EN is defined.
module alu4_req_scheduler
    import alu4_pkg::*;
#(
    parameter int unsigned WIDTH = ALU4_WIDTH,
    parameter int unsigned OPW   = ALU4_OPW
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ0_VALID,
    output logic             REQ0_READY,
    input  logic [OPW-1:0]   REQ0_OP,
    input  logic [WIDTH-1:0] REQ0_A,
    input  logic [WIDTH-1:0] REQ0_B,
    input  logic             REQ1_VALID,
    output logic             REQ1_READY,
    input  logic [OPW-1:0]   REQ1_OP,
    input  logic [WIDTH-1:0] REQ1_A,
    input  logic [WIDTH-1:0] REQ1_B,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [WIDTH-1:0] RES_OUT,
    output logic             RES_Z,
    output logic             RES_CF,
    output logic             RES_ID,
    input  logic             CLR_STICKY,
    output logic             STICKY_Z,
    output logic             STICKY_CF
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_out;
    logic             r_res_z;
    logic             r_res_cf;
    logic             r_res_id;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic             w_res_hs;
    logic [WIDTH-1:0] w_alu_out;
    logic             w_alu_z;
    logic             w_alu_cf;

    // Next state and grants; a requester equal to LAST yields only when the other is valid.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_gnt0 = REQ0_VALID && (!REQ1_VALID || r_last);
                w_gnt1 = REQ1_VALID && (!REQ0_VALID || !r_last);
                if (w_gnt0 || w_gnt1) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: w_state_nxt = S_RESP;
            S_RESP: begin
                if (RES_READY) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept = w_gnt0 || w_gnt1;
    assign w_res_hs = r_res_valid && RES_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            r_last      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_res_valid <= (w_state_nxt == S_RESP);
            if (w_accept) begin
                r_last <= w_gnt1;
            end
        end
    end

    // Operand latch on grant, result capture at the end of EXEC.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_id      <= 1'b0;
            r_res_out <= '0;
            r_res_z   <= 1'b0;
            r_res_cf  <= 1'b0;
            r_res_id  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= w_gnt1 ? REQ1_OP : REQ0_OP;
                r_a  <= w_gnt1 ? REQ1_A  : REQ0_A;
                r_b  <= w_gnt1 ? REQ1_B  : REQ0_B;
                r_id <= w_gnt1;
            end
            if (r_state == S_EXEC) begin
                r_res_out <= w_alu_out;
                r_res_z   <= w_alu_z;
                r_res_cf  <= w_alu_cf;
                r_res_id  <= r_id;
            end
        end
    end

    alu4_core #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu4_core (
        .i_op    (r_op),
        .i_a     (r_a),
        .i_b     (r_b),
        .o_out_c (w_alu_out),
        .o_z_c   (w_alu_z),
        .o_cf_c  (w_alu_cf)
    );

    assign REQ0_READY = w_gnt0;
    assign REQ1_READY = w_gnt1;
    assign RES_VALID  = r_res_valid;
    assign RES_OUT    = r_res_out;
    assign RES_Z      = r_res_z;
    assign RES_CF     = r_res_cf;
    assign RES_ID     = r_res_id;

`ifdef ALU4_STICKY_FLAGS_EN
    logic r_sticky_z;
    logic r_sticky_cf;

    // A flag delivered in the same cycle as a clear survives the clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sticky_z  <= 1'b0;
            r_sticky_cf <= 1'b0;
        end else begin
            r_sticky_z  <= (r_sticky_z  && !CLR_STICKY) || (w_res_hs && r_res_z);
            r_sticky_cf <= (r_sticky_cf && !CLR_STICKY) || (w_res_hs && r_res_cf);
        end
    end

    assign STICKY_Z  = r_sticky_z;
    assign STICKY_CF = r_sticky_cf;
`else
    logic w_unused_sticky;

    assign w_unused_sticky = CLR_STICKY ^ w_res_hs;
    assign STICKY_Z        = 1'b0;
    assign STICKY_CF       = 1'b0;
`endif

endmodule

// File: tb/tb_alu4_req_scheduler.sv
// Scoreboard bench for alu4_req_scheduler: grants push expected results, a monitor pops on handshake.
`timescale 1ns/1ps
module tb_alu4_req_scheduler;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       REQ0_VALID = 1'b0;
    logic       REQ0_READY;
    logic [1:0] REQ0_OP = '0;
    logic [3:0] REQ0_A = '0;
    logic [3:0] REQ0_B = '0;
    logic       REQ1_VALID = 1'b0;
    logic       REQ1_READY;
    logic [1:0] REQ1_OP = '0;
    logic [3:0] REQ1_A = '0;
    logic [3:0] REQ1_B = '0;
    logic       RES_VALID;
    logic       RES_READY = 1'b1;
    logic [3:0] RES_OUT;
    logic       RES_Z;
    logic       RES_CF;
    logic       RES_ID;
    logic       CLR_STICKY = 1'b0;
    logic       STICKY_Z;
    logic       STICKY_CF;

    typedef struct packed {
        logic [3:0] out;
        logic       z;
        logic       cf;
        logic       id;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   gnt_id[$];
    int   gnt_cyc[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cycle = 0;

    alu4_req_scheduler dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_READY (REQ0_READY),
        .REQ0_OP    (REQ0_OP),
        .REQ0_A     (REQ0_A),
        .REQ0_B     (REQ0_B),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_READY (REQ1_READY),
        .REQ1_OP    (REQ1_OP),
        .REQ1_A     (REQ1_A),
        .REQ1_B     (REQ1_B),
        .RES_VALID  (RES_VALID),
        .RES_READY  (RES_READY),
        .RES_OUT    (RES_OUT),
        .RES_Z      (RES_Z),
        .RES_CF     (RES_CF),
        .RES_ID     (RES_ID),
        .CLR_STICKY (CLR_STICKY),
        .STICKY_Z   (STICKY_Z),
        .STICKY_CF  (STICKY_CF)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // Monitor: grant log, one-READY rule, and scoreboard pop on every result handshake.
    always @(negedge CLK) begin
        if (RST_N) begin
            check("one_ready", 32'(REQ0_READY & REQ1_READY), 32'd0);
            if (REQ0_READY) begin gnt_id.push_back(0); gnt_cyc.push_back(cycle); end
            if (REQ1_READY) begin gnt_id.push_back(1); gnt_cyc.push_back(cycle); end
            if (RES_VALID && RES_READY) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_result", $sformatf("got RES_OUT=0x%0h, required no result", RES_OUT));
                end else begin
                    e_mon = sb.pop_front();
                    check("res_out", 32'(RES_OUT), 32'(e_mon.out));
                    check("res_z",   32'(RES_Z),   32'(e_mon.z));
                    check("res_cf",  32'(RES_CF),  32'(e_mon.cf));
                    check("res_id",  32'(RES_ID),  32'(e_mon.id));
                end
            end
        end
    end

    // Present a request, wait for its READY, push its hand-computed result; returns 1 ns after the accept edge.
    task automatic issue(input bit id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] eo, input logic ez, input logic ecf, input bit keep);
        bit got = 1'b0;
        if (id == 1'b0) begin
            REQ0_VALID = 1'b1; REQ0_OP = op; REQ0_A = a; REQ0_B = b;
        end else begin
            REQ1_VALID = 1'b1; REQ1_OP = op; REQ1_A = a; REQ1_B = b;
        end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge CLK);
            if ((id == 1'b0 && REQ0_READY) || (id == 1'b1 && REQ1_READY)) begin
                got = 1'b1;
                sb.push_back(exp_t'{eo, ez, ecf, id});
            end
        end
        if (!got) fail_now("grant_timeout", $sformatf("requester %0d got no READY, required one within 60 cycles", id));
        @(posedge CLK); #1;
        if (!keep) begin
            if (id == 1'b0) REQ0_VALID = 1'b0;
            else            REQ1_VALID = 1'b0;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && !RES_VALID) break;
            @(posedge CLK); #1;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        check("drain_valid", 32'(RES_VALID), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        check("rst_res_valid", 32'(RES_VALID), 32'd0);
        check("rst_res_out",   32'(RES_OUT),   32'd0);
        check("rst_res_z",     32'(RES_Z),     32'd0);
        check("rst_res_cf",    32'(RES_CF),    32'd0);
        check("rst_res_id",    32'(RES_ID),    32'd0);
        check("rst_ready",     32'({REQ0_READY, REQ1_READY}), 32'd0);
        check("rst_sticky",    32'({STICKY_Z, STICKY_CF}),    32'd0);
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK); #1;

        // NOT 0000 from requester 0, with latency check
        issue(1'b0, 2'b00, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
        check("t1_valid_exec", 32'(RES_VALID), 32'd0);
        @(posedge CLK); #1;
        check("t1_valid_resp", 32'(RES_VALID), 32'd1);
        wait_idle();

        // ADD 1001+0111 wraps to zero with carry
        issue(1'b1, 2'b11, 4'b1001, 4'b0111, 4'b0000, 1'b1, 1'b1, 1'b0);
        wait_idle();

        // Both requesters continuously valid: grants alternate 0,1,0,1 three cycles apart
        gnt_id.delete(); gnt_cyc.delete();
        fork
            begin
                issue(1'b0, 2'b01, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b1);
                issue(1'b0, 2'b10, 4'b0101, 4'b1010, 4'b1111, 1'b0, 1'b0, 1'b0);
            end
            begin
                issue(1'b1, 2'b11, 4'b0011, 4'b0100, 4'b0111, 1'b0, 1'b0, 1'b1);
                issue(1'b1, 2'b01, 4'b0101, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0);
            end
        join
        wait_idle();
        check("t3_gnt_count", 32'(gnt_id.size()), 32'd4);
        for (int i = 0; i < gnt_id.size(); i++) begin
            check("t3_gnt_order", 32'(gnt_id[i]), 32'(i % 2));
            if (i > 0) check("t3_gnt_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd3);
        end

        // Backpressure in RESP while requester 1 waits
        RES_READY = 1'b0;
        fork
            issue(1'b0, 2'b10, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
            issue(1'b1, 2'b00, 4'b1010, 4'b0000, 4'b0101, 1'b0, 1'b0, 1'b0);
            begin : bp_chk
                logic [3:0] s_out;
                logic       s_z;
                logic       s_cf;
                logic       s_id;
                for (int k = 0; k < 20 && !RES_VALID; k++) @(negedge CLK);
                check("t4_resp_reached", 32'(RES_VALID), 32'd1);
                s_out = RES_OUT; s_z = RES_Z; s_cf = RES_CF; s_id = RES_ID;
                check("t4_captured_out", 32'(s_out), 32'd0);
                repeat (5) begin
                    @(negedge CLK);
                    check("t4_hold_valid", 32'(RES_VALID), 32'd1);
                    check("t4_hold_data",  32'({RES_OUT, RES_Z, RES_CF, RES_ID}), 32'({s_out, s_z, s_cf, s_id}));
                    check("t4_hold_ready", 32'({REQ0_READY, REQ1_READY}), 32'd0);
                end
                @(posedge CLK); #1;
                RES_READY = 1'b1;
                @(negedge CLK);
                @(negedge CLK);
                check("t4_pending_grant", 32'(REQ1_READY), 32'd1);
            end
        join
        wait_idle();

        // Reset during EXEC after requester 0 was last: op discarded, pointer back to favour requester 0
        issue(1'b0, 2'b01, 4'b1111, 4'b0110, 4'b0110, 1'b0, 1'b0, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        check("t5_rst_valid", 32'(RES_VALID), 32'd0);
        sb.delete();
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK); #1;
        check("t5_discarded", 32'(RES_VALID), 32'd0);
        gnt_id.delete(); gnt_cyc.delete();
        fork
            issue(1'b0, 2'b11, 4'b0111, 4'b0111, 4'b1110, 1'b0, 1'b0, 1'b0);
            issue(1'b1, 2'b11, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0);
        join
        wait_idle();
        check("t5_gnt_count", 32'(gnt_id.size()), 32'd2);
        if (gnt_id.size() > 0) check("t5_first_gnt", 32'(gnt_id[0]), 32'd0);

`ifdef ALU4_STICKY_FLAGS_EN
        CLR_STICKY = 1'b1;
        @(posedge CLK); #1;
        CLR_STICKY = 1'b0;
        check("t6_clear", 32'({STICKY_Z, STICKY_CF}), 32'd0);
        issue(1'b0, 2'b11, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0);
        wait_idle();
        check("t6_after_add", 32'({STICKY_Z, STICKY_CF}), 32'b11);
        issue(1'b1, 2'b01, 4'b0011, 4'b1100, 4'b0000, 1'b1, 1'b0, 1'b0);
        wait_idle();
        check("t6_after_and", 32'({STICKY_Z, STICKY_CF}), 32'b11);
        issue(1'b0, 2'b01, 4'b0011, 4'b1100, 4'b0000, 1'b1, 1'b0, 1'b0);
        @(posedge CLK); #1;
        CLR_STICKY = 1'b1;
        @(posedge CLK); #1;
        CLR_STICKY = 1'b0;
        check("t6_clear_vs_set", 32'({STICKY_Z, STICKY_CF}), 32'b10);
        wait_idle();
`else
        CLR_STICKY = 1'b1;
        issue(1'b0, 2'b11, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0);
        CLR_STICKY = 1'b0;
        wait_idle();
        check("t6_sticky_tied", 32'({STICKY_Z, STICKY_CF}), 32'd0);
`endif

        check("final_pending", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
